// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - handshake/score bundle between a match driver and game_ctrl
// Purpose: groups the match-control inputs and the registered controller outputs.
// Ports (slave = game_ctrl side):
//   in : start, clear, mode[1:0], init_val[SIZE-1:0], winner, loser
//   out: control[1:0], INIT_l[SIZE-1:0], INIT_c, dp_clr, w_count/l_count[MAX_SCORE-1:0],
//        WHO[1:0], GAMEOVER, busy
interface game_ctrl_if #(
    parameter int SIZE      = 4,
    parameter int MAX_SCORE = 4
);
    logic                 start;
    logic                 clear;
    logic [1:0]           mode;
    logic [SIZE-1:0]      init_val;
    logic                 winner;
    logic                 loser;
    logic [1:0]           control;
    logic [SIZE-1:0]      INIT_l;
    logic                 INIT_c;
    logic                 dp_clr;
    logic [MAX_SCORE-1:0] w_count;
    logic [MAX_SCORE-1:0] l_count;
    logic [1:0]           WHO;
    logic                 GAMEOVER;
    logic                 busy;

    modport master (
        output start, clear, mode, init_val, winner, loser,
        input  control, INIT_l, INIT_c, dp_clr, w_count, l_count, WHO, GAMEOVER, busy
    );

    modport slave (
        input  start, clear, mode, init_val, winner, loser,
        output control, INIT_l, INIT_c, dp_clr, w_count, l_count, WHO, GAMEOVER, busy
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - match sequencer: load/play/score rounds until one score saturates
// Purpose: drives a counter (control/INIT_l/INIT_c) through rounds, keeps win/lose
//   scores, and reports the match result. All outputs are registered.
// Ports: clk, reset (async active-low), bus (game_ctrl_if.slave).
// Option: define GAME_CTRL_AUTO_RESTART_EN to leave OVER automatically after 8 cycles.
module game_ctrl #(
    parameter int SIZE      = 4,
    parameter int MAX_SCORE = 4
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_SCORE, S_OVER} state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [SIZE-1:0]      init_q, init_d;
    logic [MAX_SCORE-1:0] w_count_q, w_count_d;
    logic [MAX_SCORE-1:0] l_count_q, l_count_d;
    logic [1:0]           control_q, control_d;
    logic [SIZE-1:0]      init_l_q, init_l_d;
    logic                 init_c_q, init_c_d;
    logic                 dp_clr_q, dp_clr_d;
    logic [1:0]           who_q, who_d;
    logic                 gameover_q, gameover_d;
    logic                 busy_q, busy_d;
    logic                 abort;
`ifdef GAME_CTRL_AUTO_RESTART_EN
    logic [2:0]           timer_q, timer_d;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        init_d    = init_q;
        w_count_d = w_count_q;
        l_count_d = l_count_q;
        dp_clr_d  = 1'b0;
        abort     = 1'b0;
`ifdef GAME_CTRL_AUTO_RESTART_EN
        timer_d   = 3'd0;
`endif
        case (state_q)
            S_IDLE: begin
                // clear outranks start so an aborting driver never launches a match
                if (!bus.clear && bus.start) begin
                    mode_d  = bus.mode;
                    init_d  = bus.init_val;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.clear) abort = 1'b1;
                else           state_d = S_PLAY;
            end
            S_PLAY: begin
                if (bus.clear) begin
                    abort = 1'b1;
                end else if (bus.winner) begin
                    w_count_d = w_count_q + MAX_SCORE'(1);
                    state_d   = S_SCORE;
                end else if (bus.loser) begin
                    l_count_d = l_count_q + MAX_SCORE'(1);
                    state_d   = S_SCORE;
                end
            end
            S_SCORE: begin
                // a saturated score always ends the match, so counts never wrap
                if (bus.clear) begin
                    abort = 1'b1;
                end else if ((&w_count_q) || (&l_count_q)) begin
                    state_d  = S_OVER;
                    dp_clr_d = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_OVER: begin
`ifdef GAME_CTRL_AUTO_RESTART_EN
                // timer is zero on the entry cycle; reaching 7 means 8 cycles spent here
                if (bus.clear || (timer_q == 3'd7)) begin
                    state_d   = S_IDLE;
                    w_count_d = '0;
                    l_count_d = '0;
                end else begin
                    timer_d = timer_q + 3'd1;
                end
`else
                if (bus.clear) begin
                    state_d   = S_IDLE;
                    w_count_d = '0;
                    l_count_d = '0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            w_count_d = '0;
            l_count_d = '0;
            dp_clr_d  = 1'b1;
        end

        // outputs are decoded from the next state so they register alongside it
        control_d  = (state_d == S_PLAY) ? mode_d : 2'b00;
        init_l_d   = init_d;
        init_c_d   = (state_d == S_LOAD);
        gameover_d = (state_d == S_OVER);
        busy_d     = (state_d != S_IDLE);
        who_d      = (state_d == S_OVER) ? ((&w_count_d) ? 2'b01 : 2'b10) : 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            init_q     <= '0;
            w_count_q  <= '0;
            l_count_q  <= '0;
            control_q  <= 2'b00;
            init_l_q   <= '0;
            init_c_q   <= 1'b0;
            dp_clr_q   <= 1'b0;
            who_q      <= 2'b00;
            gameover_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef GAME_CTRL_AUTO_RESTART_EN
            timer_q    <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            init_q     <= init_d;
            w_count_q  <= w_count_d;
            l_count_q  <= l_count_d;
            control_q  <= control_d;
            init_l_q   <= init_l_d;
            init_c_q   <= init_c_d;
            dp_clr_q   <= dp_clr_d;
            who_q      <= who_d;
            gameover_q <= gameover_d;
            busy_q     <= busy_d;
`ifdef GAME_CTRL_AUTO_RESTART_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign bus.control  = control_q;
    assign bus.INIT_l   = init_l_q;
    assign bus.INIT_c   = init_c_q;
    assign bus.dp_clr   = dp_clr_q;
    assign bus.w_count  = w_count_q;
    assign bus.l_count  = l_count_q;
    assign bus.WHO      = who_q;
    assign bus.GAMEOVER = gameover_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    game_ctrl_if #(.SIZE(4), .MAX_SCORE(4)) bus ();

    game_ctrl #(.SIZE(4), .MAX_SCORE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_match(input logic [1:0] m, input logic [3:0] iv);
        bus.start = 1'b1; bus.mode = m; bus.init_val = iv;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b1; bus.clear = 1'b0; bus.mode = 2'b11; bus.init_val = 4'hF;
        bus.winner = 1'b1; bus.loser = 1'b1;
        tick(); tick();
        checks++; if (bus.control !== 2'b00) begin failures++; $display("FAIL reset_control actual=%b required=00", bus.control); end
        checks++; if (bus.INIT_l !== 4'h0) begin failures++; $display("FAIL reset_init_l actual=%h required=0", bus.INIT_l); end
        checks++; if ({bus.INIT_c, bus.dp_clr, bus.GAMEOVER, bus.busy} !== 4'b0000) begin failures++; $display("FAIL reset_flags actual=%b required=0000", {bus.INIT_c, bus.dp_clr, bus.GAMEOVER, bus.busy}); end
        checks++; if ({bus.w_count, bus.l_count, bus.WHO} !== 10'h0) begin failures++; $display("FAIL reset_scores actual=%h required=0", {bus.w_count, bus.l_count, bus.WHO}); end
        bus.start = 1'b0; bus.mode = 2'b00; bus.init_val = 4'h0; bus.winner = 1'b0; bus.loser = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_release_idle actual=%b required=0", bus.busy); end
    endtask

    task automatic test_start();
        bus.start = 1'b1; bus.mode = 2'b01; bus.init_val = 4'b0011;
        tick();
        bus.start = 1'b0; bus.mode = 2'b10; bus.init_val = 4'b1111;
        checks++; if (bus.INIT_c !== 1'b1) begin failures++; $display("FAIL start_init_c actual=%b required=1", bus.INIT_c); end
        checks++; if (bus.INIT_l !== 4'b0011) begin failures++; $display("FAIL start_init_l actual=%b required=0011", bus.INIT_l); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_busy actual=%b required=1", bus.busy); end
        checks++; if (bus.control !== 2'b00) begin failures++; $display("FAIL load_control actual=%b required=00", bus.control); end
        tick();
        checks++; if (bus.control !== 2'b01) begin failures++; $display("FAIL play_control actual=%b required=01", bus.control); end
        checks++; if (bus.INIT_c !== 1'b0) begin failures++; $display("FAIL play_init_c actual=%b required=0", bus.INIT_c); end
    endtask

    task automatic test_win_run();
        int dp_cycles;
        for (int i = 0; i < 15; i++) begin
            bus.winner = 1'b1;
            tick();
            bus.winner = 1'b0;
            checks++; if (bus.w_count !== 4'(i + 1)) begin failures++; $display("FAIL win_run_count round=%0d actual=%0d required=%0d", i, bus.w_count, i + 1); end
            tick();
            if (i < 14) tick();
        end
        checks++; if (bus.GAMEOVER !== 1'b1) begin failures++; $display("FAIL over_gameover actual=%b required=1", bus.GAMEOVER); end
        checks++; if (bus.WHO !== 2'b01) begin failures++; $display("FAIL over_who actual=%b required=01", bus.WHO); end
        checks++; if (bus.w_count !== 4'hF || bus.l_count !== 4'h0) begin failures++; $display("FAIL over_scores actual=%h/%h required=f/0", bus.w_count, bus.l_count); end
        checks++; if (bus.control !== 2'b00) begin failures++; $display("FAIL over_control actual=%b required=00", bus.control); end
        dp_cycles = (bus.dp_clr === 1'b1) ? 1 : 0;
        tick();
        if (bus.dp_clr === 1'b1) dp_cycles++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.dp_clr === 1'b1) dp_cycles++;
        end
        checks++; if (dp_cycles != 1) begin failures++; $display("FAIL over_dp_clr_cycles actual=%0d required=1", dp_cycles); end
`ifdef GAME_CTRL_AUTO_RESTART_EN
        tick();
        checks++; if (bus.GAMEOVER !== 1'b1) begin failures++; $display("FAIL auto_cycle7 actual=%b required=1", bus.GAMEOVER); end
        tick();
        checks++; if (bus.GAMEOVER !== 1'b0 || bus.busy !== 1'b0 || bus.w_count !== 4'h0) begin failures++; $display("FAIL auto_restart actual=%b%b%h required=000", bus.GAMEOVER, bus.busy, bus.w_count); end
`else
        begin
            int held;
            held = 0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (bus.GAMEOVER === 1'b1 && bus.w_count === 4'hF) held++;
            end
            checks++; if (held != 100) begin failures++; $display("FAIL over_persist actual=%0d required=100", held); end
        end
`endif
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++; if ({bus.GAMEOVER, bus.busy, bus.WHO, bus.w_count, bus.l_count} !== 12'h0) begin failures++; $display("FAIL over_clear actual=%h required=0", {bus.GAMEOVER, bus.busy, bus.WHO, bus.w_count, bus.l_count}); end
    endtask

    task automatic test_simultaneous();
        start_match(2'b10, 4'b0101);
        bus.winner = 1'b1; bus.loser = 1'b1;
        tick();
        checks++; if (bus.w_count !== 4'd1 || bus.l_count !== 4'd0) begin failures++; $display("FAIL simul_scores actual=%0d/%0d required=1/0", bus.w_count, bus.l_count); end
        checks++; if (bus.control !== 2'b00 || bus.INIT_c !== 1'b0) begin failures++; $display("FAIL simul_score_state actual=%b%b required=000", bus.control, bus.INIT_c); end
        tick();
        checks++; if (bus.INIT_c !== 1'b1 || bus.INIT_l !== 4'b0101 || bus.w_count !== 4'd1) begin failures++; $display("FAIL simul_reload actual=%b %b %0d required=1 0101 1", bus.INIT_c, bus.INIT_l, bus.w_count); end
        bus.winner = 1'b0; bus.loser = 1'b0;
        tick();
        checks++; if (bus.control !== 2'b10) begin failures++; $display("FAIL round2_control actual=%b required=10", bus.control); end
        bus.loser = 1'b1;
        tick();
        bus.loser = 1'b0;
        checks++; if (bus.w_count !== 4'd1 || bus.l_count !== 4'd1) begin failures++; $display("FAIL loser_scores actual=%0d/%0d required=1/1", bus.w_count, bus.l_count); end
        tick(); tick();
        bus.start = 1'b1; bus.mode = 2'b01;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.control !== 2'b10 || bus.INIT_c !== 1'b0) begin failures++; $display("FAIL start_ignored actual=%b%b required=100", bus.control, bus.INIT_c); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) begin
            bus.winner = 1'b1;
            tick();
            bus.winner = 1'b0;
            tick(); tick();
        end
        checks++; if (bus.w_count !== 4'b0101) begin failures++; $display("FAIL abort_pre_count actual=%b required=0101", bus.w_count); end
        bus.clear = 1'b1; bus.winner = 1'b1;
        tick();
        bus.clear = 1'b0; bus.winner = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.w_count !== 4'h0 || bus.l_count !== 4'h0) begin failures++; $display("FAIL abort_idle actual=%b %h %h required=0 0 0", bus.busy, bus.w_count, bus.l_count); end
        checks++; if (bus.dp_clr !== 1'b1) begin failures++; $display("FAIL abort_dp_clr actual=%b required=1", bus.dp_clr); end
        tick();
        checks++; if (bus.dp_clr !== 1'b0) begin failures++; $display("FAIL abort_dp_clr_end actual=%b required=0", bus.dp_clr); end
        bus.start = 1'b1; bus.clear = 1'b1;
        tick();
        bus.start = 1'b0; bus.clear = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.INIT_c !== 1'b0) begin failures++; $display("FAIL start_clear_idle actual=%b%b required=00", bus.busy, bus.INIT_c); end
    endtask

    task automatic test_async_reset();
        start_match(2'b11, 4'b1010);
        checks++; if (bus.control !== 2'b11) begin failures++; $display("FAIL async_pre_control actual=%b required=11", bus.control); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (bus.control !== 2'b00 || bus.busy !== 1'b0 || bus.INIT_l !== 4'h0) begin failures++; $display("FAIL async_reset_now actual=%b %b %h required=00 0 0", bus.control, bus.busy, bus.INIT_l); end
        #2;
        reset = 1'b1;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL async_wait_idle actual=%b required=0", bus.busy); end
        bus.start = 1'b1; bus.mode = 2'b01; bus.init_val = 4'b0110;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.INIT_c !== 1'b1 || bus.INIT_l !== 4'b0110) begin failures++; $display("FAIL async_fresh_match actual=%b %b required=1 0110", bus.INIT_c, bus.INIT_l); end
        tick();
        checks++; if (bus.control !== 2'b01 || bus.w_count !== 4'h0) begin failures++; $display("FAIL async_fresh_play actual=%b %h required=01 0", bus.control, bus.w_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_start();
        test_win_run();
        test_simultaneous();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
